// File: rtl/unibus_tracer_pkg.sv
// Shared definitions for the Unibus cycle tracer: trace entry layout, bus function codes, FSM states.
package unibus_tracer_pkg;

  localparam int unsigned ENTRY_W     = 50;
  localparam int unsigned DELTA_MSB   = 49;
  localparam int unsigned DELTA_LSB   = 38;
  localparam int unsigned LOST_BIT    = 37;
  localparam int unsigned TIMEOUT_BIT = 36;
  localparam int unsigned C_MSB       = 35;
  localparam int unsigned C_LSB       = 34;
  localparam int unsigned A_MSB       = 33;
  localparam int unsigned A_LSB       = 16;
  localparam int unsigned D_MSB       = 15;
  localparam int unsigned D_LSB       = 0;

  localparam logic [1:0] FN_DATI  = 2'b00;
  localparam logic [1:0] FN_DATIP = 2'b01;
  localparam logic [1:0] FN_DATO  = 2'b10;
  localparam logic [1:0] FN_DATOB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUAL,
    ST_WAITSSYN,
    ST_WAITEND
  } state_t;

  function automatic logic is_write(input logic [1:0] fn);
    return (fn == FN_DATO) || (fn == FN_DATOB);
  endfunction

  function automatic logic is_read(input logic [1:0] fn);
    return (fn == FN_DATI) || (fn == FN_DATIP);
  endfunction

endpackage

// File: rtl/unibus_tracer_fifo.sv
// trace_fifo: single-clock synchronous FIFO with occupancy count; reads zero when empty.
module trace_fifo #(
  parameter int unsigned WIDTH = 50,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           rd_data
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A pop on a full FIFO frees the slot for a same-cycle push; a pop on an empty FIFO is ignored.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/unibus_tracer.sv
// Passive Unibus tracer: qualifies MSYN/SSYN handshakes and logs each transfer into trace_fifo.
// Define UNIBUS_TRACER_TIMESTAMP_EN to fill the delta field with clocks between address latches.
module unibus_tracer
  import unibus_tracer_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     trace_en,
  input  logic [17:0]              a_in_h,
  input  logic [1:0]               c_in_h,
  input  logic [15:0]              d_in_h,
  input  logic                     msyn_in_h,
  input  logic                     ssyn_in_h,
  input  logic                     init_in_h,
  output logic [49:0]              trace_data,
  output logic                     trace_valid,
  input  logic                     trace_pop,
  output logic [$clog2(DEPTH):0]   trace_count
);
  localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t                       state_q, state_d;
  logic [17:0]                  a_q, a_d;
  logic [1:0]                   c_q, c_d;
  logic [15:0]                  dat_q, dat_d;
  logic                         seen_q, seen_d;
  logic [TW-1:0]                tcnt_q, tcnt_d;
  logic                         lost_q, lost_d;
  logic                         latch, push_req, push_to, pop_eff, fifo_full, fifo_empty;
  logic [15:0]                  push_dat;
  logic [DELTA_MSB-DELTA_LSB:0] delta_val;
  logic [ENTRY_W-1:0]           entry;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    c_d      = c_q;
    dat_d    = dat_q;
    seen_d   = 1'b0;
    tcnt_d   = tcnt_q;
    latch    = 1'b0;
    push_req = 1'b0;
    push_to  = 1'b0;
    push_dat = dat_q;
    unique case (state_q)
      ST_IDLE: if (msyn_in_h && trace_en) state_d = ST_QUAL;
      ST_QUAL: begin
        if (msyn_in_h) begin
          latch   = 1'b1;
          a_d     = a_in_h;
          c_d     = c_in_h;
          if (is_write(c_in_h)) dat_d = d_in_h;
          state_d = ST_WAITSSYN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAITSSYN: begin
        tcnt_d = tcnt_q + TW'(1);
        if (!msyn_in_h) begin
          state_d = ST_IDLE;
        end else if (ssyn_in_h && seen_q) begin
          push_req = 1'b1;
          if (is_read(c_q)) begin
            dat_d    = d_in_h;
            push_dat = d_in_h;
          end
          state_d = ST_WAITEND;
        end else if (tcnt_q == TO_LAST) begin
          push_req = 1'b1;
          push_to  = 1'b1;
          if (is_read(c_q)) push_dat = '0;
          state_d = ST_WAITEND;
        end else begin
          seen_d = ssyn_in_h;
        end
      end
      ST_WAITEND: if (!msyn_in_h) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (init_in_h) begin
      state_d  = ST_IDLE;
      latch    = 1'b0;
      push_req = 1'b0;
      seen_d   = 1'b0;
    end
    if (latch) tcnt_d = '0;
  end

  // A dropped push marks lost; the next accepted push carries it and clears it.
  always_comb begin
    pop_eff = trace_pop && trace_valid;
    lost_d  = push_req ? (fifo_full && !pop_eff) : lost_q;
    entry                         = '0;
    entry[DELTA_MSB:DELTA_LSB]    = delta_val;
    entry[LOST_BIT]               = lost_q;
    entry[TIMEOUT_BIT]            = push_to;
    entry[C_MSB:C_LSB]            = c_q;
    entry[A_MSB:A_LSB]            = a_q;
    entry[D_MSB:D_LSB]            = push_dat;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      c_q     <= '0;
      dat_q   <= '0;
      seen_q  <= 1'b0;
      tcnt_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      c_q     <= c_d;
      dat_q   <= dat_d;
      seen_q  <= seen_d;
      tcnt_q  <= tcnt_d;
      lost_q  <= lost_d;
    end
  end

`ifdef UNIBUS_TRACER_TIMESTAMP_EN
  logic [11:0] ts_q, ts_d, delta_q, delta_d;

  always_comb begin
    ts_d    = (&ts_q) ? ts_q : ts_q + 12'd1;
    delta_d = delta_q;
    if (latch) begin
      delta_d = ts_q;
      ts_d    = 12'd1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ts_q    <= '0;
      delta_q <= '0;
    end else begin
      ts_q    <= ts_d;
      delta_q <= delta_d;
    end
  end

  assign delta_val = delta_q;
`else
  assign delta_val = '0;
`endif

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLOCK),
    .rst       (RESET),
    .push      (push_req),
    .push_data (entry),
    .pop       (trace_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (trace_count),
    .rd_data   (trace_data)
  );

  assign trace_valid = !fifo_empty;

endmodule

// File: tb/tb_unibus_tracer.sv
// Self-checking bench for unibus_tracer: directed vector table, hand sequences, randomized bus cycles vs a queue model.
`timescale 1ns/1ps
module tb_unibus_tracer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic          CLOCK = 1'b0;
  logic          RESET, trace_en, msyn_in_h, ssyn_in_h, init_in_h, trace_pop, trace_valid;
  logic [17:0]   a_in_h;
  logic [1:0]    c_in_h;
  logic [15:0]   d_in_h;
  logic [49:0]   trace_data;
  logic [CW-1:0] trace_count;

  always #5 CLOCK = ~CLOCK;

  unibus_tracer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .trace_en(trace_en), .a_in_h(a_in_h), .c_in_h(c_in_h),
    .d_in_h(d_in_h), .msyn_in_h(msyn_in_h), .ssyn_in_h(ssyn_in_h), .init_in_h(init_in_h),
    .trace_data(trace_data), .trace_valid(trace_valid), .trace_pop(trace_pop), .trace_count(trace_count)
  );

  typedef enum int {K_OK, K_GLITCH, K_ABORT, K_NOSLAVE, K_INIT} kind_t;
  typedef struct {
    kind_t         kind;
    logic [1:0]    c;
    logic [17:0]   a;
    logic [15:0]   dm;
    logic [15:0]   ds;
    int unsigned   sdel;
    int unsigned   exp_n;
    logic          exp_to;
    logic [15:0]   exp_d;
  } vec_t;

  int errors = 0;
  int checks = 0;
  longint unsigned edge_idx = 0;
  longint unsigned ts_ref   = 0;
  logic [49:0] mq[$];
  logic        m_lost = 1'b0, m_latch = 1'b0, m_push = 1'b0;
  logic [11:0] m_dpend = '0;
  logic [49:0] m_entry = '0;
  bit          rand_pop = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: model the FIFO/lost/delta rules at the edge, then compare outputs 1 ns later.
  task automatic tick();
    logic [49:0] e;
    if (rand_pop) trace_pop = ($urandom_range(0, 2) == 0);
    @(posedge CLOCK);
    edge_idx++;
    if (RESET) begin
      mq.delete();
      m_lost  = 1'b0;
      m_dpend = '0;
      ts_ref  = edge_idx + 1;
    end else begin
      if (trace_pop && mq.size() > 0) void'(mq.pop_front());
      if (m_latch) begin
`ifdef UNIBUS_TRACER_TIMESTAMP_EN
        m_dpend = ((edge_idx - ts_ref) > 4095) ? 12'd4095 : 12'(edge_idx - ts_ref);
`else
        m_dpend = '0;
`endif
        ts_ref = edge_idx;
      end
      if (m_push) begin
        if (mq.size() < DEPTH) begin
          e        = m_entry;
          e[49:38] = m_dpend;
          e[37]    = m_lost;
          mq.push_back(e);
          m_lost = 1'b0;
        end else begin
          m_lost = 1'b1;
        end
      end
    end
    #1;
    chk("trace_valid", 64'(trace_valid), 64'(mq.size() > 0));
    chk("trace_count", 64'(trace_count), 64'(mq.size()));
    chk("trace_data", 64'(trace_data), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
  endtask

  task automatic pop_one();
    trace_pop = 1'b1;
    tick();
    trace_pop = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 2 && mq.size() > 0; i++) pop_one();
    chk("drained", 64'(trace_count), 64'd0);
  endtask

  // Drive one bus transaction; the bench knows from its own waveform which edge latches and which pushes.
  task automatic bus_cycle(input kind_t kind, input logic [1:0] c, input logic [17:0] a,
                           input logic [15:0] dm, input logic [15:0] ds, input int unsigned sdel,
                           input bit rec, input bit pop_at_push);
    a_in_h = a; c_in_h = c; d_in_h = dm; msyn_in_h = 1'b1;
    tick();
    if (kind == K_GLITCH) begin
      msyn_in_h = 1'b0;
      tick(); tick();
      return;
    end
    m_latch = rec;
    tick();
    m_latch = 1'b0;
    d_in_h  = 16'($urandom);
    m_entry = '0;
    m_entry[35:34] = c;
    m_entry[33:16] = a;
    case (kind)
      K_OK: begin
        repeat (sdel - 1) tick();
        ssyn_in_h = 1'b1; d_in_h = ds;
        tick();
        m_entry[15:0] = c[1] ? dm : ds;
        m_push = rec;
        if (pop_at_push) trace_pop = 1'b1;
        tick();
        m_push = 1'b0; trace_pop = 1'b0;
        d_in_h = ~ds;
        repeat (2) tick();
      end
      K_ABORT: begin
        ssyn_in_h = 1'b1; tick();
        ssyn_in_h = 1'b0; repeat (2) tick();
      end
      K_NOSLAVE: begin
        repeat (TIMEOUT - 1) tick();
        m_entry[36]   = 1'b1;
        m_entry[15:0] = c[1] ? dm : 16'h0000;
        m_push = rec;
        tick();
        m_push = 1'b0;
        repeat (3) tick();
      end
      K_INIT: begin
        ssyn_in_h = 1'b1; tick();
        init_in_h = 1'b1; tick();
        init_in_h = 1'b0; msyn_in_h = 1'b0; ssyn_in_h = 1'b0; tick();
      end
      default: tick();
    endcase
    msyn_in_h = 1'b0; ssyn_in_h = 1'b0;
    tick(); tick();
  endtask

  task automatic head_chk(input string name, input logic [17:0] a_exp, input logic lost_exp);
    chk({name, "_a"}, 64'(trace_data[33:16]), 64'(a_exp));
    chk({name, "_lost"}, 64'(trace_data[37]), 64'(lost_exp));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    vt[0] = '{kind:K_OK,      c:2'b00, a:18'o165020, dm:16'h0000,  ds:16'o012706, sdel:2, exp_n:1, exp_to:1'b0, exp_d:16'o012706};
    vt[1] = '{kind:K_OK,      c:2'b10, a:18'o001000, dm:16'o177777, ds:16'o000000, sdel:1, exp_n:1, exp_to:1'b0, exp_d:16'o177777};
    vt[2] = '{kind:K_NOSLAVE, c:2'b00, a:18'o760000, dm:16'h0000,  ds:16'h0000,   sdel:1, exp_n:1, exp_to:1'b1, exp_d:16'h0000};
    vt[3] = '{kind:K_GLITCH,  c:2'b00, a:18'o000100, dm:16'h0000,  ds:16'h1234,   sdel:1, exp_n:0, exp_to:1'b0, exp_d:16'h0000};
    vt[4] = '{kind:K_ABORT,   c:2'b10, a:18'o000200, dm:16'h5555,  ds:16'h0000,   sdel:1, exp_n:0, exp_to:1'b0, exp_d:16'h0000};
    vt[5] = '{kind:K_INIT,    c:2'b01, a:18'o000300, dm:16'h0000,  ds:16'h7777,   sdel:1, exp_n:0, exp_to:1'b0, exp_d:16'h0000};
    vt[6] = '{kind:K_OK,      c:2'b11, a:18'o017776, dm:16'o000377, ds:16'o123456, sdel:4, exp_n:1, exp_to:1'b0, exp_d:16'o000377};
    vt[7] = '{kind:K_NOSLAVE, c:2'b10, a:18'o777560, dm:16'o052525, ds:16'h0000,   sdel:1, exp_n:1, exp_to:1'b1, exp_d:16'o052525};

    RESET = 1'b1; trace_en = 1'b1; msyn_in_h = 1'b0; ssyn_in_h = 1'b0; init_in_h = 1'b0;
    trace_pop = 1'b0; a_in_h = '0; c_in_h = '0; d_in_h = '0;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    chk("reset_valid", 64'(trace_valid), 64'd0);
    chk("reset_count", 64'(trace_count), 64'd0);
    chk("reset_data", 64'(trace_data), 64'd0);

    foreach (vt[i]) begin
      bus_cycle(vt[i].kind, vt[i].c, vt[i].a, vt[i].dm, vt[i].ds, vt[i].sdel, 1'b1, 1'b0);
      chk($sformatf("vec%0d_count", i), 64'(trace_count), 64'(vt[i].exp_n));
      if (vt[i].exp_n != 0) begin
        chk($sformatf("vec%0d_a", i), 64'(trace_data[33:16]), 64'(vt[i].a));
        chk($sformatf("vec%0d_c", i), 64'(trace_data[35:34]), 64'(vt[i].c));
        chk($sformatf("vec%0d_d", i), 64'(trace_data[15:0]), 64'(vt[i].exp_d));
        chk($sformatf("vec%0d_to", i), 64'(trace_data[36]), 64'(vt[i].exp_to));
        pop_one();
      end
    end

    // INIT mid-cycle leaves an existing entry untouched.
    bus_cycle(K_OK, 2'b00, 18'o004000, 16'h0, 16'hbeef, 1, 1'b1, 1'b0);
    bus_cycle(K_INIT, 2'b00, 18'o004002, 16'h0, 16'h1111, 1, 1'b1, 1'b0);
    chk("init_keep_count", 64'(trace_count), 64'd1);
    chk("init_keep_d", 64'(trace_data[15:0]), 64'hbeef);
    pop_one();

    trace_en = 1'b0;
    bus_cycle(K_OK, 2'b00, 18'o004004, 16'h0, 16'h2222, 1, 1'b0, 1'b0);
    chk("disabled_count", 64'(trace_count), 64'd0);
    trace_en = 1'b1;

    // Overflow: 6 cycles into 4 slots, then the lost flag travels with the next accepted entry only.
    for (int i = 0; i < 6; i++) bus_cycle(K_OK, 2'b00, 18'(i), 16'h0, 16'(i), 1, 1'b1, 1'b0);
    chk("full_count", 64'(trace_count), 64'd4);
    head_chk("full_head", 18'd0, 1'b0);
    pop_one();
    bus_cycle(K_OK, 2'b00, 18'd6, 16'h0, 16'd6, 1, 1'b1, 1'b0);
    chk("refill_count", 64'(trace_count), 64'd4);
    repeat (3) pop_one();
    head_chk("lost_entry", 18'd6, 1'b1);
    pop_one();
    bus_cycle(K_OK, 2'b00, 18'd7, 16'h0, 16'd7, 1, 1'b1, 1'b0);
    head_chk("after_lost", 18'd7, 1'b0);
    pop_one();
    for (int i = 8; i < 12; i++) bus_cycle(K_OK, 2'b00, 18'(i), 16'h0, 16'(i), 1, 1'b1, 1'b0);
    bus_cycle(K_OK, 2'b00, 18'd12, 16'h0, 16'd12, 1, 1'b1, 1'b1);
    chk("pushpop_full_count", 64'(trace_count), 64'd4);
    head_chk("pushpop_head", 18'd9, 1'b0);
    repeat (3) pop_one();
    head_chk("pushpop_tail", 18'd12, 1'b0);
    drain();

`ifdef UNIBUS_TRACER_TIMESTAMP_EN
    bus_cycle(K_OK, 2'b00, 18'o010000, 16'h0, 16'h1111, 1, 1'b1, 1'b0);
    repeat (91) tick();
    pop_one();
    bus_cycle(K_OK, 2'b00, 18'o010002, 16'h0, 16'h2222, 1, 1'b1, 1'b0);
    chk("delta_100", 64'(trace_data[49:38]), 64'd100);
    pop_one();
    repeat (5000) tick();
    bus_cycle(K_OK, 2'b00, 18'o010004, 16'h0, 16'h3333, 1, 1'b1, 1'b0);
    chk("delta_sat", 64'(trace_data[49:38]), 64'd4095);
    pop_one();
`else
    bus_cycle(K_OK, 2'b00, 18'o010000, 16'h0, 16'h1111, 1, 1'b1, 1'b0);
    chk("delta_off", 64'(trace_data[49:38]), 64'd0);
    pop_one();
`endif

    rand_pop = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      kind_t k;
      r = $urandom_range(0, 99);
      k = (r < 55) ? K_OK : (r < 70) ? K_GLITCH : (r < 85) ? K_ABORT : (r < 97) ? K_INIT : K_NOSLAVE;
      bus_cycle(k, 2'($urandom), 18'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(1, 4), 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_pop = 1'b0;
    trace_pop = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unibus_tracer.md
# unibus_tracer

Passive Unibus cycle tracer that sits on the wire-ANDed bus next to the simulated 11/34, M9312 ROM and Zynq bus interface, consuming the active-high copies of the bus lines. It records every master/slave data transfer (address, function, data, completion status, optional timestamp) into a FIFO, and the ARM-side register logic drains that FIFO. It never drives the bus.

## Interface
- `DEPTH`, 16: FIFO entries, power of two, 4..256.
- `TIMEOUT`, 1000: clocks from a qualified MSYN to SSYN before the cycle is declared a bus timeout (10 µs at 100 MHz).
- `CLOCK` in 1: 100 MHz clock.
- `RESET` in 1: synchronous, active-high reset.
- `trace_en` in 1: 1=record cycles; 0=finish the current cycle, then stay in IDLE.
- `a_in_h` in 18: bus address, active-high.
- `c_in_h` in 2: bus function (00 DATI, 01 DATIP, 10 DATO, 11 DATOB).
- `d_in_h` in 16: bus data, active-high.
- `msyn_in_h` in 1: master sync.
- `ssyn_in_h` in 1: slave sync.
- `init_in_h` in 1: bus init; aborts the cycle in progress without recording it.
- `trace_data` out 50: FIFO head, {delta[49:38], lost[37], timeout[36], c[35:34], a[33:16], d[15:0]}.
- `trace_valid` out 1: FIFO non-empty.
- `trace_pop` in 1: consume the head. Ignored when `trace_valid`=0.
- `trace_count` out log2(DEPTH)+1: number of entries held.

## Operation
- States: IDLE, QUAL, WAITSSYN, WAITEND.
- IDLE: when `msyn_in_h`=1 and `trace_en`=1, go to QUAL.
- QUAL: if `msyn_in_h`=1 again, latch a and c, go to WAITSSYN. For DATO/DATOB (c[1]=1), also latch d here. If `msyn_in_h`=0, return to IDLE (glitch, not recorded).
- WAITSSYN: on the second consecutive `ssyn_in_h`=1 sample:
  - DATI/DATIP: latch d.
  - Push the entry with timeout=0.
  - Go to WAITEND.
- WAITSSYN timeout: if TIMEOUT clocks elapse since latch without qualified SSYN, push the entry with timeout=1. For DATI/DATIP, d=0. Go to WAITEND.
- WAITSSYN abort: if `msyn_in_h` drops before qualified SSYN, nothing is pushed; go to IDLE.
- WAITEND: go to IDLE once `msyn_in_h`=0. This prevents double recording of a slow cycle.
- `init_in_h`=1 in any state: go to IDLE next clock. No push. The FIFO is retained.
- FIFO full on push: the entry is dropped and the sticky `lost` flag is set. `lost` is written into the next accepted entry and then cleared.
- Push and pop in the same clock:
  - Always legal.
  - When full, the pop frees the slot and the push is accepted.
  - When empty, the push is accepted; the pop is ignored.
- Read/write pointers wrap modulo DEPTH. `trace_count` is 0..DEPTH.

## Timing
- Reset values:
  - state=IDLE
  - FIFO empty, `trace_valid`=0, `trace_count`=0
  - `trace_data`=0
  - `lost`=0
  - timeout counter=0, delta counter=0
- Address latch occurs on the second clock edge at which `msyn_in_h`=1. Minimum qualified MSYN width is 2 clocks.
- Push occurs on the second edge with `ssyn_in_h`=1. `trace_valid` rises and `trace_data` is valid on the following clock (1-clock push-to-head latency).
- Pop: the head advances on the edge where `trace_pop`=1. The new head, or `trace_valid`=0, appears the same cycle after that edge.
- Timeout push: exactly TIMEOUT clocks after the address latch edge.

## Configuration
- `UNIBUS_TRACER_TIMESTAMP_EN` defined:
  - A 12-bit counter counts clocks between successive address latches, saturating at 4095.
  - Its value is stored in delta[49:38], then the counter resets to 1.
  - The counter is cleared by RESET.
- Undefined: delta field is constant 0 and the counter is not built.

## Structure
- Shared package holds:
  - Field position constants for `trace_data` (DELTA_MSB/LSB, LOST_BIT, TIMEOUT_BIT, C_MSB/LSB, A_MSB/LSB, D_MSB/LSB).
  - Bus function codes DATI/DATIP/DATO/DATOB.
  - State encoding.
- One sub-module, `trace_fifo`: synchronous single-clock FIFO, parameterised width and depth, exposing push/pop/full/count. The tracer FSM and lost logic stay in `unibus_tracer`.

## Test plan
- DATI a=0o165020, ROM drives d=0o012706 with SSYN 3 clocks after MSYN → one entry, c=00, a=0o165020, d=0o012706, timeout=0, valid 1 clock after second SSYN sample.
- DATO a=0o001000, d=0o177777 → entry d=0o177777 latched at MSYN qualify, even though d is changed after SSYN.
- DATI to a=0o760000 with no slave → entry pushed exactly 1000 clocks after latch, timeout=1, d=0. No second entry while MSYN stays asserted.
- 1-clock MSYN glitch, then MSYN dropped mid-WAITSSYN → no entries. `init_in_h` pulse mid-cycle → IDLE, no entry, FIFO contents unchanged.
- DEPTH=4: 6 cycles without popping → count=4, cycles 5–6 dropped. Pop one, run one more → new entry has lost=1; the following entry has lost=0. Push+pop in the same clock while full → count stays 4.
- With `UNIBUS_TRACER_TIMESTAMP_EN`: cycles 100 clocks apart → delta=100. A gap of 5000 clocks → delta=4095. Without the macro → delta=0.
